// File: rtl/psum_pkg.sv
// psum_pkg: shared defaults and the state type for the partial-sum accumulator.
//   Tout         - output-channel lanes per beat
//   W_PSUM       - bits per lane (two's complement)
//   BUF_AW       - psum RAM address width
//   PSUM_FLAT_BW - packed width of one beat of lanes
//   state_t      - IDLE / ACCUM / DRAIN
package psum_pkg;
  localparam int unsigned Tout         = 4;
  localparam int unsigned W_PSUM       = 32;
  localparam int unsigned BUF_AW       = 16;
  localparam int unsigned PSUM_FLAT_BW = Tout * W_PSUM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/psum_ram.sv
// psum_ram: simple dual-port RAM, one write port and one synchronous read port.
// A read and a write to the same address in one cycle return the old contents.
// The array has no reset.
//   clk_i   - clock
//   we_i    - write enable, waddr_i / wdata_i - write address / data
//   re_i    - read enable,  raddr_i           - read address
//   rdata_o - read data, valid the cycle after re_i
module psum_ram
  import psum_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 128
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates PE partial sums over all input-channel tiles of
// one output tile in an internal RAM (read-modify-write with forwarding) and
// emits the final per-pixel sums over valid/ready on the last channel tile.
// Optional build macro: PSUM_RELU_EN clamps negative final lanes to zero.
//   clk, rst (async, active-high)
//   cfg_start, cfg_width, cfg_height, cfg_q_channel - tile configuration
//   pe_vld, pe_row, pe_col, pe_acc                  - PE beat stream (no backpressure)
//   o_vld, o_ready, o_data, o_row, o_col            - final result handshake
//   o_busy, o_done, o_err                           - status
module psum_accumulator #(
  parameter int unsigned Tout      = psum_pkg::Tout,
  parameter int unsigned W_PSUM    = psum_pkg::W_PSUM,
  parameter int unsigned W_SIZE    = 9,
  parameter int unsigned W_CHANNEL = 10,
  parameter int unsigned BUF_AW    = psum_pkg::BUF_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [W_SIZE-1:0]      cfg_width,
  input  logic [W_SIZE-1:0]      cfg_height,
  input  logic [W_CHANNEL-1:0]   cfg_q_channel,
  input  logic                   pe_vld,
  input  logic [W_SIZE-1:0]      pe_row,
  input  logic [W_SIZE-1:0]      pe_col,
  input  logic [Tout*W_PSUM-1:0] pe_acc,
  output logic                   o_vld,
  input  logic                   o_ready,
  output logic [Tout*W_PSUM-1:0] o_data,
  output logic [W_SIZE-1:0]      o_row,
  output logic [W_SIZE-1:0]      o_col,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);
  import psum_pkg::state_t;
  import psum_pkg::IDLE;
  import psum_pkg::ACCUM;
  import psum_pkg::DRAIN;

  localparam int unsigned FW = Tout * W_PSUM;
  localparam int unsigned PW = 2 * W_SIZE;

  state_t state_q, state_d;

  logic [W_SIZE-1:0]    cfg_w_q;
  logic [W_CHANNEL-1:0] cfg_q_q;
  logic [PW-1:0]        pix_last_q, pix_cnt_q;
  logic [W_CHANNEL-1:0] tile_q;

  logic              s0_vld_q, s0_first_q, s0_last_q;
  logic [BUF_AW-1:0] s0_addr_q;
  logic [W_SIZE-1:0] s0_row_q, s0_col_q;
  logic [FW-1:0]     s0_acc_q;

  logic              s1_vld_q, s1_first_q, s1_last_q;
  logic [BUF_AW-1:0] s1_addr_q;
  logic [W_SIZE-1:0] s1_row_q, s1_col_q;
  logic [FW-1:0]     s1_acc_q;

  logic              fwd_vld_q;
  logic [BUF_AW-1:0] fwd_addr_q;
  logic [FW-1:0]     fwd_data_q;

  logic              out_vld_q, err_q;
  logic [FW-1:0]     out_data_q;
  logic [W_SIZE-1:0] out_row_q, out_col_q;

  logic          accept, done, pix_end, tile_end, drained, idle_hit, ram_we, load;
  logic [FW-1:0] ram_rdata, old, sum, fin;

  assign pix_end  = (pix_cnt_q == pix_last_q);
  assign tile_end = (tile_q == cfg_q_q - W_CHANNEL'(1));
  assign drained  = !s0_vld_q && !s1_vld_q && !out_vld_q;
  assign idle_hit = pe_vld && !cfg_start && (state_q == IDLE);
  assign ram_we   = s1_vld_q && !s1_last_q;
  assign load     = s1_vld_q && s1_last_q;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE:  if (cfg_start) state_d = ACCUM;
      ACCUM: begin
        accept = pe_vld && !cfg_start;
        if (accept && pix_end && tile_end) state_d = DRAIN;
      end
      DRAIN: if (drained) begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (cfg_start) begin
      state_d = ACCUM;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The previous cycle's RAM write lands on the same edge this beat's read was
  // sampled, so the read returned stale data; take the registered write instead.
  always_comb begin
    old = (fwd_vld_q && (fwd_addr_q == s1_addr_q)) ? fwd_data_q : ram_rdata;
    sum = '0;
    fin = '0;
    for (int unsigned g = 0; g < Tout; g++) begin
      sum[g*W_PSUM +: W_PSUM] = s1_first_q ? s1_acc_q[g*W_PSUM +: W_PSUM]
                                           : old[g*W_PSUM +: W_PSUM] + s1_acc_q[g*W_PSUM +: W_PSUM];
      fin[g*W_PSUM +: W_PSUM] = sum[g*W_PSUM +: W_PSUM];
`ifdef PSUM_RELU_EN
      if (sum[g*W_PSUM + W_PSUM - 1]) fin[g*W_PSUM +: W_PSUM] = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_w_q    <= '0;
      cfg_q_q    <= '0;
      pix_last_q <= '0;
      pix_cnt_q  <= '0;
      tile_q     <= '0;
      s0_vld_q   <= 1'b0;
      s0_first_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_addr_q  <= '0;
      s0_row_q   <= '0;
      s0_col_q   <= '0;
      s0_acc_q   <= '0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_addr_q  <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_acc_q   <= '0;
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      err_q      <= 1'b0;
    end else if (cfg_start) begin
      cfg_w_q    <= cfg_width;
      cfg_q_q    <= cfg_q_channel;
      pix_last_q <= PW'(cfg_width) * PW'(cfg_height) - PW'(1);
      pix_cnt_q  <= '0;
      tile_q     <= '0;
      s0_vld_q   <= 1'b0;
      s1_vld_q   <= 1'b0;
      fwd_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      // S0: register the beat; its RAM read is sampled on the next edge.
      s0_vld_q <= accept;
      if (accept) begin
        s0_addr_q  <= BUF_AW'(pe_row) * BUF_AW'(cfg_w_q) + BUF_AW'(pe_col);
        s0_row_q   <= pe_row;
        s0_col_q   <= pe_col;
        s0_acc_q   <= pe_acc;
        s0_first_q <= (tile_q == '0);
        s0_last_q  <= tile_end;
        if (pix_end) begin
          pix_cnt_q <= '0;
          tile_q    <= tile_q + W_CHANNEL'(1);
        end else begin
          pix_cnt_q <= pix_cnt_q + PW'(1);
        end
      end
      // S1: RAM data is valid while the beat sits here.
      s1_vld_q   <= s0_vld_q;
      s1_first_q <= s0_first_q;
      s1_last_q  <= s0_last_q;
      s1_addr_q  <= s0_addr_q;
      s1_row_q   <= s0_row_q;
      s1_col_q   <= s0_col_q;
      s1_acc_q   <= s0_acc_q;
      fwd_vld_q  <= ram_we;
      fwd_addr_q <= s1_addr_q;
      fwd_data_q <= sum;
      if (load) begin
        out_vld_q  <= 1'b1;
        out_data_q <= fin;
        out_row_q  <= s1_row_q;
        out_col_q  <= s1_col_q;
        if (out_vld_q && !o_ready) err_q <= 1'b1;
      end else if (out_vld_q && o_ready) begin
        out_vld_q <= 1'b0;
      end
      if (idle_hit) err_q <= 1'b1;
    end
  end

  psum_ram #(
    .AW(BUF_AW),
    .DW(FW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(s1_addr_q),
    .wdata_i(sum),
    .re_i   (s0_vld_q),
    .raddr_i(s0_addr_q),
    .rdata_o(ram_rdata)
  );

  assign o_vld  = out_vld_q;
  assign o_data = out_data_q;
  assign o_row  = out_row_q;
  assign o_col  = out_col_q;
  assign o_busy = (state_q != IDLE);
  assign o_done = done;
  assign o_err  = err_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: per-pixel sums are computed in plain arithmetic as
// beats are issued; final sums are scheduled two cycles after capture and fed
// through a one-entry output buffer model driven by the observed o_ready.
module tb_psum_accumulator;
  localparam int FW = psum_pkg::PSUM_FLAT_BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic [8:0]    cfg_width = '0, cfg_height = '0;
  logic [9:0]    cfg_q_channel = '0;
  logic          pe_vld = 1'b0;
  logic [8:0]    pe_row = '0, pe_col = '0;
  logic [FW-1:0] pe_acc = '0;
  logic          o_vld, o_ready = 1'b1;
  logic [FW-1:0] o_data;
  logic [8:0]    o_row, o_col;
  logic          o_busy, o_done, o_err;

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_q_channel(cfg_q_channel), .pe_vld(pe_vld),
    .pe_row(pe_row), .pe_col(pe_col), .pe_acc(pe_acc), .o_vld(o_vld),
    .o_ready(o_ready), .o_data(o_data), .o_row(o_row), .o_col(o_col),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  typedef struct packed {
    logic [FW-1:0] d;
    logic [8:0]    r;
    logic [8:0]    c;
  } out_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FW-1:0] msum [0:255];
  out_t arr [int];
  bit   clr_at [int];
  bit   err_at [int];
  bit   m_full = 0, m_err = 0, hs_acc;
  out_t m_out;
  logic rdy_prev = 1'b1;
  int   hs_cnt = 0, done_cnt = 0;
  logic [FW-1:0] last_hs = '0;
  int   m_w, m_h, m_q, m_k;
  bit   rmode = 0;
  logic rhold = 1'b1;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] fin(input logic [FW-1:0] s);
    logic [FW-1:0] r = s;
`ifdef PSUM_RELU_EN
    for (int g = 0; g < 4; g++) if (r[g*32+31]) r[g*32 +: 32] = '0;
`endif
    return r;
  endfunction

  // Compare process: one-entry output buffer model, checked every cycle.
  always @(negedge clk) begin
    if (rst) begin
      m_full = 0; m_err = 0;
      arr.delete(); clr_at.delete(); err_at.delete();
      chk("rst_o_vld", o_vld, 0);
      chk("rst_o_data", o_data, '0);
      chk("rst_o_row", o_row, 0);
      chk("rst_o_col", o_col, 0);
      chk("rst_o_busy", o_busy, 0);
      chk("rst_o_done", o_done, 0);
      chk("rst_o_err", o_err, 0);
    end else begin
      hs_acc = m_full && rdy_prev;
      if (clr_at.exists(cyc)) begin
        m_full = 0; m_err = 0;
        clr_at.delete(cyc);
        if (arr.exists(cyc)) arr.delete(cyc);
      end else if (arr.exists(cyc)) begin
        if (m_full && !hs_acc) m_err = 1;
        m_full = 1;
        m_out  = arr[cyc];
        arr.delete(cyc);
      end else if (hs_acc) begin
        m_full = 0;
      end
      if (err_at.exists(cyc)) begin
        m_err = 1;
        err_at.delete(cyc);
      end
      chk("o_vld", o_vld, m_full);
      if (m_full) begin
        chk("o_data", o_data, m_out.d);
        chk("o_row", o_row, m_out.r);
        chk("o_col", o_col, m_out.c);
      end
      chk("o_err", o_err, m_err);
      if (o_vld && o_ready) begin
        hs_cnt++;
        last_hs = o_data;
      end
      if (o_done) done_cnt++;
    end
    rdy_prev = o_ready;
  end

  task automatic tick();
    @(posedge clk); #1;
    pe_vld    = 1'b0;
    cfg_start = 1'b0;
    o_ready   = rmode ? 1'($urandom_range(0, 1)) : rhold;
  endtask

  task automatic start(input int w, input int h, input int q);
    tick();
    cfg_start = 1'b1;
    cfg_width = 9'(w); cfg_height = 9'(h); cfg_q_channel = 10'(q);
    m_w = w; m_h = h; m_q = q; m_k = 0;
    clr_at[cyc + 1] = 1;
  endtask

  task automatic beat(input logic [FW-1:0] a);
    int tot, pix, tile;
    out_t o;
    tot  = m_w * m_h;
    pix  = m_k % tot;
    tile = m_k / tot;
    tick();
    pe_vld = 1'b1;
    pe_row = 9'(pix / m_w);
    pe_col = 9'(pix % m_w);
    pe_acc = a;
    for (int g = 0; g < 4; g++)
      msum[pix][g*32 +: 32] = (tile == 0) ? a[g*32 +: 32] : msum[pix][g*32 +: 32] + a[g*32 +: 32];
    if (tile == m_q - 1) begin
      o.d = fin(msum[pix]);
      o.r = 9'(pix / m_w);
      o.c = 9'(pix % m_w);
      arr[cyc + 3] = o;
    end
    m_k++;
  endtask

  task automatic wait_done(input string name);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({name, "_done_once"}, done_cnt - d0, 1);
    chk({name, "_busy_low"}, o_busy, 0);
  endtask

  function automatic logic [FW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int h0, w, h, q;
    logic [FW-1:0] exp;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    chk("reset_busy", o_busy, 0);

    // 2x2 frame, three tiles of lanes 1,2,3 -> every lane 6
    h0 = hs_cnt;
    start(2, 2, 3);
    for (int t = 0; t < 3; t++)
      for (int p = 0; p < 4; p++) beat({4{32'(t + 1)}});
    wait_done("t1");
    chk("t1_outputs", hs_cnt - h0, 4);
    chk("t1_lanes_6", last_hs, {4{32'd6}});
    chk("t1_err", o_err, 0);

    // 1x1 frame, four back-to-back beats: forwarding path
    start(1, 1, 4);
    repeat (4) beat({32'd0, 32'd7, 32'hFFFF_FFFF, 32'd5});
    wait_done("t2");
`ifdef PSUM_RELU_EN
    exp = {32'd0, 32'd28, 32'd0, 32'd20};
`else
    exp = {32'd0, 32'd28, 32'hFFFF_FFFC, 32'd20};
`endif
    chk("t2_forward_sum", last_hs, exp);

    // o_ready low while two last-tile pixels arrive: overwrite + error
    rhold = 1'b0;
    start(2, 1, 1);
    beat({4{32'd11}});
    beat({4{32'd22}});
    repeat (4) tick();
    chk("t3_err", o_err, 1);
    chk("t3_vld", o_vld, 1);
    chk("t3_data_second", o_data, {4{32'd22}});
    chk("t3_col_second", o_col, 1);
    rhold = 1'b1;
    wait_done("t3");

    // Wrap-around across two tiles
    start(1, 1, 2);
    beat({96'd0, 32'h7FFF_FFFF});
    beat({96'd0, 32'h0000_0001});
    wait_done("t4");
`ifdef PSUM_RELU_EN
    chk("t4_wrap", last_hs, '0);
`else
    chk("t4_wrap", last_hs, {96'd0, 32'h8000_0000});
`endif

`ifdef PSUM_RELU_EN
    start(1, 1, 1);
    beat({32'd0, 32'h8000_0000, 32'd4, 32'hFFFF_FFFD});
    wait_done("t5");
    chk("t5_relu", last_hs, {32'd0, 32'd0, 32'd4, 32'd0});
`endif

    // Abort mid-ACCUM with rst
    start(2, 2, 2);
    repeat (3) beat(rnd());
    tick();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_vld", o_vld, 0);

    // pe_vld while IDLE: dropped, sticky error, no output
    tick();
    pe_vld = 1'b1;
    pe_acc = rnd();
    err_at[cyc + 1] = 1;
    repeat (3) tick();
    chk("idle_err", o_err, 1);
    chk("idle_no_vld", o_vld, 0);

    // Clean tile after abort, then random tiles with random o_ready
    rmode = 1;
    start(2, 2, 2);
    for (int k = 0; k < 8; k++) beat(rnd());
    wait_done("post_abort");
    for (int n = 0; n < 8; n++) begin
      w = $urandom_range(1, 4);
      h = $urandom_range(1, 4);
      q = $urandom_range(1, 4);
      start(w, h, q);
      for (int k = 0; k < w * h * q; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        beat(rnd());
      end
      wait_done("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
